jk_bank_arbiter: RTL and testbench

//  Shares one bank of WIDTH JK flip-flops between NREQ requesters.
//  - Each requester presents per-bit J/K masks with a valid/ready handshake.
//  - A round-robin arbiter picks one requester per cycle.
//  - The winner's masks are applied to the bank with the JK rule
//    Q <= (J & ~Q) | (~K & Q).
//  - Sits between control agents and the shared JK state register. It

---
 rtl/jk_bank_arbiter_if.sv | 25 ++
 rtl/jk_bank_arbiter.sv | 129 ++++++++++++
 tb/tb_jk_bank_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/jk_bank_arbiter_if.sv
// Requester-side bus of the shared JK bank arbiter.
// Signals (per requester i, masks packed at [i*WIDTH +: WIDTH]):
//   req_valid   requester i has a command pending
//   req_ready_c one-hot grant, combinational
//   req_j/req_k per-bit J/K masks
//   req_lock    keep priority after a transfer (only with ARB_LOCK_EN)
// Modports: master = requester side, slave = arbiter side.
interface jk_bank_arbiter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready_c;
  logic [NREQ*WIDTH-1:0] req_j;
  logic [NREQ*WIDTH-1:0] req_k;
`ifdef ARB_LOCK_EN
  logic [NREQ-1:0]       req_lock;

  modport master (output req_valid, req_j, req_k, req_lock, input req_ready_c);
  modport slave  (input req_valid, req_j, req_k, req_lock, output req_ready_c);
`else
  modport master (output req_valid, req_j, req_k, input req_ready_c);
  modport slave  (input req_valid, req_j, req_k, output req_ready_c);
`endif
endinterface

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing one bank of WIDTH JK flip-flops between NREQ
// requesters. The winner's masks are applied at the transfer edge with
// Q <= (J & ~Q) | (~K & Q).
// Ports:
//   clk_i        rising-edge clock
//   rst_n_i      synchronous active-low reset
//   req          requester bus (jk_bank_arbiter_if.slave)
//   q_o          JK bank state, registered
//   gnt_valid_o  a command was applied at the last edge
//   gnt_id_o     requester whose command was applied (holds when idle)
//   cmd_count_o  commands applied since reset, saturating
// Optional feature: define ARB_LOCK_EN to add req_lock; a locked transfer
// leaves the round-robin pointer on the winner so it keeps priority.
module jk_bank_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4,
  localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int unsigned CW   = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  jk_bank_arbiter_if.slave req,
  output logic [WIDTH-1:0] q_o,
  output logic             gnt_valid_o,
  output logic [IDW-1:0]   gnt_id_o,
  output logic [CW-1:0]    cmd_count_o
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             xfer_c;
  logic [IDW-1:0]   win_c;
  logic [NREQ-1:0]  gnt_c;
  logic [WIDTH-1:0] j_c, k_c;
  logic             lock_c;

  // Round-robin pick: first pass covers [ptr, NREQ-1], second wraps to [0, ptr-1].
  always_comb begin
    xfer_c = 1'b0;
    win_c  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!xfer_c && req.req_valid[i] && (32'(ptr_q) <= i)) begin
        xfer_c = 1'b1;
        win_c  = IDW'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!xfer_c && req.req_valid[i]) begin
        xfer_c = 1'b1;
        win_c  = IDW'(i);
      end
    end
    // No grant is offered while reset is asserted.
    if (!rst_n_i) begin
      xfer_c = 1'b0;
    end
  end

  // One-hot ready and winner mask/lock selection.
  always_comb begin
    gnt_c  = '0;
    j_c    = '0;
    k_c    = '0;
    lock_c = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_c == IDW'(i)) begin
        gnt_c[i] = xfer_c;
        j_c      = req.req_j[i*WIDTH +: WIDTH];
        k_c      = req.req_k[i*WIDTH +: WIDTH];
`ifdef ARB_LOCK_EN
        lock_c   = req.req_lock[i];
`endif
      end
    end
  end

  assign req.req_ready_c = gnt_c;

  // Next state: bank update, pointer advance (or stay when locked), grant info, count.
  always_comb begin
    q_d         = q_q;
    ptr_d       = ptr_q;
    gnt_valid_d = 1'b0;
    gnt_id_d    = gnt_id_q;
    cnt_d       = cnt_q;
    if (xfer_c) begin
      q_d         = (j_c & ~q_q) | (~k_c & q_q);
      gnt_valid_d = 1'b1;
      gnt_id_d    = win_c;
      if (cnt_q != {CW{1'b1}}) begin
        cnt_d = cnt_q + CW'(1);
      end
      if (lock_c) begin
        ptr_d = win_c;
      end else if (win_c == IDW'(NREQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = win_c + IDW'(1);
      end
    end
  end

  // State registers; reset wins over a same-cycle command.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      q_q         <= '0;
      ptr_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      cnt_q       <= '0;
    end else begin
      q_q         <= q_d;
      ptr_q       <= ptr_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      cnt_q       <= cnt_d;
    end
  end

  assign q_o         = q_q;
  assign gnt_valid_o = gnt_valid_q;
  assign gnt_id_o    = gnt_id_q;
  assign cmd_count_o = cnt_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter (WIDTH=8, NREQ=4).
module tb_jk_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  jm [4];
  logic [7:0]  km [4];
  logic [7:0]  q;
  logic        gnt_valid;
  logic [1:0]  gnt_id;
  logic [15:0] cmd_count;

  logic [7:0]  qm;
  logic [15:0] cntm;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  jk_bank_arbiter_if #(.WIDTH(8), .NREQ(4)) bus ();

  assign bus.req_j = {jm[3], jm[2], jm[1], jm[0]};
  assign bus.req_k = {km[3], km[2], km[1], km[0]};
`ifdef ARB_LOCK_EN
  logic [3:0] lock_m;
  assign bus.req_lock = lock_m;
`endif

  jk_bank_arbiter #(.WIDTH(8), .NREQ(4)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req         (bus.slave),
    .q_o         (q),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id),
    .cmd_count_o (cmd_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] jk(input logic [7:0] qv, input logic [7:0] j, input logic [7:0] k);
    return (j & ~qv) | (~k & qv);
  endfunction

  // One cycle: check ready before the edge, then grant info/state after it.
  task automatic cyc(input string tag, input int w);
    logic [3:0] er;
    er = (w < 0) ? 4'b0000 : 4'(1 << w);
    #1;
    check({tag, "_ready"}, 32'(bus.req_ready_c), 32'(er));
    @(posedge clk); #1;
    if (w >= 0) begin
      qm = jk(qm, jm[w], km[w]);
      if (cntm != 16'hFFFF) cntm = cntm + 16'd1;
      check({tag, "_gnt_valid"}, 32'(gnt_valid), 32'd1);
      check({tag, "_gnt_id"}, 32'(gnt_id), 32'(w));
    end else begin
      check({tag, "_gnt_valid"}, 32'(gnt_valid), 32'd0);
    end
    check({tag, "_q"}, 32'(q), 32'(qm));
    check({tag, "_count"}, 32'(cmd_count), 32'(cntm));
  endtask

  task automatic do_reset(input string tag, input int n);
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_ready"}, 32'(bus.req_ready_c), 32'd0);
    repeat (n) @(posedge clk);
    #1;
    qm   = 8'h00;
    cntm = 16'h0000;
    check({tag, "_rst_q"}, 32'(q), 32'd0);
    check({tag, "_rst_count"}, 32'(cmd_count), 32'd0);
    check({tag, "_rst_gnt_valid"}, 32'(gnt_valid), 32'd0);
    check({tag, "_rst_gnt_id"}, 32'(gnt_id), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      jm[i] = 8'hFF;
      km[i] = 8'h00;
    end
`ifdef ARB_LOCK_EN
    lock_m = 4'b0000;
`endif
    qm   = 8'h00;
    cntm = 16'h0000;

    // Reset with every requester valid
    do_reset("t1", 2);

    // Single requester: set upper nibble, then toggle all
    bus.req_valid = 4'b0010;
    jm[1] = 8'hF0; km[1] = 8'h00;
    cyc("t2a", 1);
    jm[1] = 8'hFF; km[1] = 8'hFF;
    cyc("t2b", 1);
    check("t2_q_final", 32'(q), 32'h0F);
    check("t2_count", 32'(cmd_count), 32'd2);

    // Round-robin over all four with distinct masks
    do_reset("t3", 1);
    for (int i = 0; i < 4; i++) begin
      jm[i] = 8'(8'h11 << i);
      km[i] = 8'(8'h81 >> i);
    end
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) cyc("t3", c % 4);
    check("t3_count", 32'(cmd_count), 32'd8);

    // Wrap from P=3 to req0, idle hold, then req3 ahead of req0
    bus.req_valid = 4'b0100;
    cyc("t4a", 2);
    bus.req_valid = 4'b0001;
    cyc("t4b", 0);
    bus.req_valid = 4'b0000;
    repeat (3) cyc("t4idle", -1);
    check("t4_id_hold", 32'(gnt_id), 32'd0);
    bus.req_valid = 4'b1001;
    cyc("t4c", 3);
    cyc("t4d", 0);
    bus.req_valid = 4'b0100;
    cyc("t4e", 2);

    // Reset during a req2 J=FF transfer; pointer returns to 0
    jm[2] = 8'hFF; km[2] = 8'h00;
    bus.req_valid = 4'b0100;
    do_reset("t5", 1);
    jm[1] = 8'h01; km[1] = 8'h00;
    bus.req_valid = 4'b1110;
    cyc("t5", 1);

    // Lock behaviour (or plain rotation without the lock feature)
    do_reset("t6", 1);
    bus.req_valid = 4'b0001;
    cyc("t6a", 0);
    bus.req_valid = 4'b0111;
`ifdef ARB_LOCK_EN
    lock_m = 4'b0010;
    repeat (3) cyc("t6lock", 1);
    lock_m = 4'b0000;
`else
    cyc("t6b", 1);
    cyc("t6c", 2);
    cyc("t6d", 0);
`endif
    bus.req_valid = 4'b0101;
    cyc("t6e", 2);

    // Counter saturation
    do_reset("t7", 1);
    jm[0] = 8'h00; km[0] = 8'h00;
    bus.req_valid = 4'b0001;
    repeat (65534) @(posedge clk);
    #1;
    check("t7_count_fffe", 32'(cmd_count), 32'h0000FFFE);
    cntm = 16'hFFFE;
    repeat (3) cyc("t7sat", 0);
    check("t7_count_sat", 32'(cmd_count), 32'h0000FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
